// File: rtl/wb_stage.sv
// Writeback pipeline stage: registers the memory-stage bundle, extracts and extends
// load data, selects the register-file write value and counts retired instructions.
module wb_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  valid_m,
    input  logic                  reg_write_m,
    input  logic [4:0]            rd_m,
    input  logic [1:0]            result_src_m,
    input  logic [2:0]            funct3_m,
    input  logic [DATA_WIDTH-1:0] alu_result_m,
    input  logic [DATA_WIDTH-1:0] read_data_m,
    input  logic [DATA_WIDTH-1:0] pc_plus4_m,
    input  logic [DATA_WIDTH-1:0] imm_ext_m,
    output logic [4:0]            AD3,
    output logic                  WE3,
    output logic [DATA_WIDTH-1:0] WD3,
    output logic                  valid_w,
    output logic                  retire,
    output logic [31:0]           instret
);

    logic                  valid_reg;
    logic                  reg_write_reg;
    logic [4:0]            rd_reg;
    logic [1:0]            result_src_reg;
    logic [2:0]            funct3_reg;
    logic [DATA_WIDTH-1:0] alu_result_reg;
    logic [DATA_WIDTH-1:0] read_data_reg;
    logic [DATA_WIDTH-1:0] pc_plus4_reg;
    logic [DATA_WIDTH-1:0] imm_ext_reg;
    logic [31:0]           instret_reg;

    logic                  capture;
    logic [7:0]            lanes [4];
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_value;

    // Bubbles only clear valid; payload fields keep their previous contents.
    assign capture = valid_m & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg      <= 1'b0;
            reg_write_reg  <= 1'b0;
            rd_reg         <= '0;
            result_src_reg <= '0;
            funct3_reg     <= '0;
            alu_result_reg <= '0;
            read_data_reg  <= '0;
            pc_plus4_reg   <= '0;
            imm_ext_reg    <= '0;
            instret_reg    <= '0;
        end else if (en) begin
            valid_reg <= capture;
            if (capture) begin
                reg_write_reg  <= reg_write_m;
                rd_reg         <= rd_m;
                result_src_reg <= result_src_m;
                funct3_reg     <= funct3_m;
                alu_result_reg <= alu_result_m;
                read_data_reg  <= read_data_m;
                pc_plus4_reg   <= pc_plus4_m;
                imm_ext_reg    <= imm_ext_m;
            end
            if (valid_reg) begin
                instret_reg <= instret_reg + 32'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = read_data_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        byte_sel = lanes[alu_result_reg[1:0]];
        half_sel = alu_result_reg[1] ? {lanes[3], lanes[2]} : {lanes[1], lanes[0]};
        case (funct3_reg)
            3'b000:  load_value = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b100:  load_value = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            3'b001:  load_value = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            3'b101:  load_value = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: load_value = read_data_reg;
        endcase
    end

    always_comb begin
        case (result_src_reg)
            2'b00:   WD3 = alu_result_reg;
            2'b01:   WD3 = load_value;
            2'b10:   WD3 = pc_plus4_reg;
            default: WD3 = imm_ext_reg;
        endcase
    end

    assign AD3     = rd_reg;
    assign WE3     = valid_reg & reg_write_reg & (rd_reg != 5'd0);
    assign valid_w = valid_reg;
    assign retire  = valid_reg & en;
    assign instret = instret_reg;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized self-checking bench for wb_stage against a transaction-level model
// of the writeback register, load extraction and retire counter.
module tb_wb_stage;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          flush;
    logic          valid_m;
    logic          reg_write_m;
    logic [4:0]    rd_m;
    logic [1:0]    result_src_m;
    logic [2:0]    funct3_m;
    logic [DW-1:0] alu_result_m;
    logic [DW-1:0] read_data_m;
    logic [DW-1:0] pc_plus4_m;
    logic [DW-1:0] imm_ext_m;
    logic [4:0]    AD3;
    logic          WE3;
    logic [DW-1:0] WD3;
    logic          valid_w;
    logic          retire;
    logic [31:0]   instret;

    wb_stage #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .flush        (flush),
        .valid_m      (valid_m),
        .reg_write_m  (reg_write_m),
        .rd_m         (rd_m),
        .result_src_m (result_src_m),
        .funct3_m     (funct3_m),
        .alu_result_m (alu_result_m),
        .read_data_m  (read_data_m),
        .pc_plus4_m   (pc_plus4_m),
        .imm_ext_m    (imm_ext_m),
        .AD3          (AD3),
        .WE3          (WE3),
        .WD3          (WD3),
        .valid_w      (valid_w),
        .retire       (retire),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int txn      = 0;

    // Reference state: the instruction the stage is believed to hold.
    bit          m_valid, m_rw;
    int unsigned m_rd, m_src, m_f3, m_alu, m_rdata, m_pc4, m_imm, m_instret;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int unsigned model_load();
        int unsigned b, h;
        b = (m_rdata >> (8 * (m_alu % 4))) & 32'hFF;
        h = (m_rdata >> (16 * ((m_alu / 2) % 2))) & 32'hFFFF;
        case (m_f3)
            0:       return (b >= 128) ? b - 256 : b;
            4:       return b;
            1:       return (h >= 32768) ? h - 65536 : h;
            5:       return h;
            default: return m_rdata;
        endcase
    endfunction

    function automatic int unsigned model_wd3();
        case (m_src)
            0:       return m_alu;
            1:       return model_load();
            2:       return m_pc4;
            default: return m_imm;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_rd = 0; m_src = 0; m_f3 = 0;
        m_alu = 0; m_rdata = 0; m_pc4 = 0; m_imm = 0; m_instret = 0;
    endtask

    task automatic check_all(input string where);
        check_value({where, ".ad3"}, 64'(AD3), 64'(m_rd));
        check_value({where, ".we3"}, 64'(WE3), 64'(m_valid && m_rw && m_rd != 0));
        check_value({where, ".wd3"}, 64'(WD3), 64'(model_wd3()));
        check_value({where, ".valid_w"}, 64'(valid_w), 64'(m_valid));
        check_value({where, ".retire"}, 64'(retire), 64'(m_valid && en));
        check_value({where, ".instret"}, 64'(instret), 64'(m_instret));
    endtask

    // Present one transaction, check the current WB view, then commit it at the edge.
    task automatic step(input bit e, input bit f, input bit v, input bit rw,
                        input logic [4:0] rd, input logic [1:0] src, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [31:0] pc4, input logic [31:0] imm);
        @(negedge clk);
        en = e; flush = f; valid_m = v; reg_write_m = rw; rd_m = rd;
        result_src_m = src; funct3_m = f3; alu_result_m = alu;
        read_data_m = rdata; pc_plus4_m = pc4; imm_ext_m = imm;
        #1;
        check_all($sformatf("t%0d", txn));
        @(posedge clk);
        if (e) begin
            if (m_valid) m_instret = m_instret + 1;
            m_valid = v && !f;
            if (v && !f) begin
                m_rw = rw; m_rd = rd; m_src = src; m_f3 = f3;
                m_alu = alu; m_rdata = rdata; m_pc4 = pc4; m_imm = imm;
            end
        end
        $display("txn %0d en=%0b flush=%0b valid=%0b rd=%0d src=%0d f3=%0d alu=%08h rdata=%08h",
                 txn, e, f, v, rd, src, f3, alu, rdata);
        txn++;
    endtask

    task automatic idle(input bit e);
        step(e, 0, 0, 0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    int unsigned saved;

    initial begin
        rst = 1; en = 0; flush = 0; valid_m = 0; reg_write_m = 0; rd_m = 0;
        result_src_m = 0; funct3_m = 0; alu_result_m = 0; read_data_m = 0;
        pc_plus4_m = 0; imm_ext_m = 0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 0;

        // Basic ALU write, one-edge latency, count after following edge
        step(1, 0, 1, 1, 5'd5, 2'd0, 3'd2, 32'h1234, 32'h0, 32'h0, 32'h0);
        #1;
        check_value("alu.ad3", 64'(AD3), 64'd5);
        check_value("alu.we3", 64'(WE3), 64'd1);
        check_value("alu.wd3", 64'(WD3), 64'h1234);
        check_value("alu.retire", 64'(retire), 64'd1);
        idle(1);
        #1;
        check_value("alu.instret", 64'(instret), 64'd1);

        // Load extraction
        step(1, 0, 1, 1, 5'd7, 2'd1, 3'd0, 32'h1002, 32'h11802233, 0, 0);
        #1; check_value("lb", 64'(WD3), 64'hFFFFFF80);
        step(1, 0, 1, 1, 5'd7, 2'd1, 3'd4, 32'h1002, 32'h11802233, 0, 0);
        #1; check_value("lbu", 64'(WD3), 64'h00000080);
        step(1, 0, 1, 1, 5'd7, 2'd1, 3'd1, 32'h1002, 32'h11802233, 0, 0);
        #1; check_value("lh", 64'(WD3), 64'h00001180);
        step(1, 0, 1, 1, 5'd7, 2'd1, 3'd5, 32'h1002, 32'h80002233, 0, 0);
        #1; check_value("lhu", 64'(WD3), 64'h00008000);

        // x0 write suppression, link and immediate selects
        step(1, 0, 1, 1, 5'd0, 2'd0, 3'd0, 32'h55, 0, 0, 0);
        #1; check_value("x0.we3", 64'(WE3), 64'd0);
        step(1, 0, 1, 1, 5'd1, 2'd2, 3'd0, 32'h55, 0, 32'h104, 0);
        #1; check_value("link.wd3", 64'(WD3), 64'h104);
        step(1, 0, 1, 1, 5'd2, 2'd3, 3'd0, 32'h55, 0, 0, 32'hABCDE000);
        #1; check_value("lui.wd3", 64'(WD3), 64'hABCDE000);

        // Stall: three held cycles (flush ignored), then exactly one retire
        saved = m_instret;
        step(0, 1, 1, 1, 5'd9, 2'd0, 3'd0, 32'hDEAD, 0, 0, 0);
        step(0, 0, 1, 1, 5'd9, 2'd0, 3'd0, 32'hDEAD, 0, 0, 0);
        step(0, 0, 1, 1, 5'd9, 2'd0, 3'd0, 32'hDEAD, 0, 0, 0);
        #1; check_value("stall.instret", 64'(instret), 64'(saved));
        check_value("stall.wd3", 64'(WD3), 64'hABCDE000);
        idle(1);
        #1; check_value("stall.release", 64'(instret), 64'(saved + 1));

        // Flush drops incoming but retires the current one
        step(1, 0, 1, 1, 5'd3, 2'd0, 3'd0, 32'h77, 0, 0, 0);
        saved = m_instret;
        step(1, 1, 1, 1, 5'd4, 2'd0, 3'd0, 32'h88, 0, 0, 0);
        #1;
        check_value("flush.valid_w", 64'(valid_w), 64'd0);
        check_value("flush.we3", 64'(WE3), 64'd0);
        check_value("flush.instret", 64'(instret), 64'(saved + 1));

        // Counter wrap
        step(1, 0, 1, 1, 5'd6, 2'd0, 3'd0, 32'h99, 0, 0, 0);
        #2;
        force dut.instret_reg = 32'hFFFF_FFFF;
        #1;
        release dut.instret_reg;
        m_instret = 32'hFFFF_FFFF;
        idle(1);
        #1; check_value("wrap.instret", 64'(instret), 64'd0);

        // Asynchronous reset mid-stall discards the held instruction
        step(1, 0, 1, 1, 5'd8, 2'd0, 3'd0, 32'hCAFE, 0, 0, 0);
        step(0, 0, 0, 0, 5'd0, 2'd0, 3'd0, 0, 0, 0, 0);
        #2;
        rst = 1;
        #1;
        model_reset();
        check_all("async_rst");
        #3;
        rst = 0;
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 75, 1'($urandom), 5'($urandom),
                 2'($urandom), 3'($urandom), $urandom, $urandom, $urandom, $urandom);
        end
        idle(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
